// File: rtl/mips_pkg.sv
// Shared types and field positions for the MIPS issue stage.
package mips_pkg;

  // Decoded control bundle; regwrite is the MSB.
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       branch;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Register specifier geometry inside an instruction word.
  localparam int unsigned REG_W  = 5;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned IMM_W  = 16;

endpackage

// File: rtl/id_ex_issue_hazard_fwd.sv
// Operand forwarding from M and load-use hazard detection (combinational).
module hazard_fwd
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rt_d,
  input  logic             valid_d,
  input  logic [XLEN-1:0]  rd1,
  input  logic [XLEN-1:0]  rd2,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [XLEN-1:0]  aluout_m,
  input  logic             valid_e,
  input  logic             memtoreg_e,
  input  logic [REG_W-1:0] writereg_e,
  output logic [XLEN-1:0]  srca_d,
  output logic [XLEN-1:0]  srcb_d,
  output logic             lu_hit
);

  logic fwd_ok_m;
  logic load_e;
  logic load_m;
  logic match_e;
  logic match_m;

  // Only a non-load M result is available to forward; register 0 never is.
  always_comb begin
    fwd_ok_m = regwrite_m & ~memtoreg_m & (writereg_m != '0);
    srca_d   = (fwd_ok_m && (writereg_m == rs_d)) ? aluout_m : rd1;
    srcb_d   = (fwd_ok_m && (writereg_m == rt_d)) ? aluout_m : rd2;
  end

  // A load in E or M whose destination is a source of the decode slot stalls it.
  always_comb begin
    load_e  = valid_e & memtoreg_e & (writereg_e != '0);
    load_m  = regwrite_m & memtoreg_m & (writereg_m != '0);
    match_e = (writereg_e == rs_d) | (uses_rt_d & (writereg_e == rt_d));
    match_m = (writereg_m == rs_d) | (uses_rt_d & (writereg_m == rt_d));
    lu_hit  = valid_d & ((load_e & match_e) | (load_m & match_m));
  end

endmodule

// File: rtl/id_ex_issue.sv
// Decode-to-execute issue stage: regfile addressing, forwarding, load-use stall, ID/EX register.
module id_ex_issue
  import mips_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            instr_d,
  input  logic [31:0]            pcplus4_d,
  input  logic                   valid_d,
  input  ctrl_t                  ctrl_d,
  input  logic                   uses_rt_d,
  output logic [4:0]             ra1,
  output logic [4:0]             ra2,
  input  logic [XLEN-1:0]        rd1,
  input  logic [XLEN-1:0]        rd2,
  input  logic                   regwrite_m,
  input  logic                   memtoreg_m,
  input  logic [4:0]             writereg_m,
  input  logic [XLEN-1:0]        aluout_m,
  input  logic                   hold_e,
  input  logic                   flush_e,
  output logic                   stall_d,
  output logic                   valid_e,
  output ctrl_t                  ctrl_e,
  output logic [XLEN-1:0]        srca_e,
  output logic [XLEN-1:0]        writedata_e,
  output logic [XLEN-1:0]        signimm_e,
  output logic [4:0]             rs_e,
  output logic [4:0]             rt_e,
  output logic [4:0]             writereg_e,
  output logic [31:0]            pcplus4_e,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic [REG_W-1:0] rd_d;
  logic [REG_W-1:0] rd_e;
  logic [XLEN-1:0]  srca_d;
  logic [XLEN-1:0]  srcb_d;
  logic [XLEN-1:0]  signimm_d;
  logic             lu_hit;
  logic             bubble;
  logic [5:0]       unused_opcode;

  // Field extraction; the opcode is consumed by the upstream decoder, not here.
  always_comb begin
    rs_d          = instr_d[RS_LSB +: REG_W];
    rt_d          = instr_d[RT_LSB +: REG_W];
    rd_d          = instr_d[RD_LSB +: REG_W];
    signimm_d     = {{(XLEN-IMM_W){instr_d[IMM_W-1]}}, instr_d[IMM_W-1:0]};
    unused_opcode = instr_d[31:26];
    ra1           = rs_d;
    ra2           = rt_d;
  end

  hazard_fwd #(.XLEN(XLEN)) u_hazard_fwd (
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .uses_rt_d  (uses_rt_d),
    .valid_d    (valid_d),
    .rd1        (rd1),
    .rd2        (rd2),
    .regwrite_m (regwrite_m),
    .memtoreg_m (memtoreg_m),
    .writereg_m (writereg_m),
    .aluout_m   (aluout_m),
    .valid_e    (valid_e),
    .memtoreg_e (ctrl_e.memtoreg),
    .writereg_e (writereg_e),
    .srca_d     (srca_d),
    .srcb_d     (srcb_d),
    .lu_hit     (lu_hit)
  );

  // Stall and bubble decisions; flush never affects the decode stall.
  always_comb begin
    stall_d    = lu_hit | hold_e;
    bubble     = flush_e | lu_hit | ~valid_d;
    writereg_e = ctrl_e.regdst ? rd_e : rt_e;
  end

  // ID/EX register: hold beats flush, bubbles are driven fully to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e     <= 1'b0;
      ctrl_e      <= CTRL_NOP;
      srca_e      <= '0;
      writedata_e <= '0;
      signimm_e   <= '0;
      rs_e        <= '0;
      rt_e        <= '0;
      rd_e        <= '0;
      pcplus4_e   <= '0;
    end else if (hold_e) begin
      valid_e     <= valid_e;
    end else if (bubble) begin
      valid_e     <= 1'b0;
      ctrl_e      <= CTRL_NOP;
      srca_e      <= '0;
      writedata_e <= '0;
      signimm_e   <= '0;
      rs_e        <= '0;
      rt_e        <= '0;
      rd_e        <= '0;
      pcplus4_e   <= '0;
    end else begin
      valid_e     <= 1'b1;
      ctrl_e      <= ctrl_d;
      srca_e      <= srca_d;
      writedata_e <= srcb_d;
      signimm_e   <= signimm_d;
      rs_e        <= rs_d;
      rt_e        <= rt_d;
      rd_e        <= rd_d;
      pcplus4_e   <= pcplus4_d;
    end
  end

  // Saturating count of load-use stall cycles not masked by an EX hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (lu_hit && !hold_e && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Decode-to-execute issue stage: the block directly downstream of the register file.
- Drives the register file read addresses and forwards operands from the memory stage.
- Detects load-use hazards and stalls decode; holds the ID/EX pipeline register, including bubble and flush handling.
- Keeps a saturating stall-cycle counter for performance visibility.

Parameters:
- XLEN, 32, datapath width.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instr_d  in  32  decode-stage instruction.
- pcplus4_d  in  32  decode PC+4.
- valid_d  in  1  decode slot holds a real instruction.
- ctrl_d  in  ctrl_t (9)  decoded control bundle.
- uses_rt_d  in  1  instruction reads rt as a source.
- ra1  out  5  register file read address 1, equal to instr_d[25:21].
- ra2  out  5  register file read address 2, equal to instr_d[20:16].
- rd1  in  XLEN  register file read data 1.
- rd2  in  XLEN  register file read data 2.
- regwrite_m  in  1  M-stage instruction writes a register.
- memtoreg_m  in  1  M-stage instruction is a load.
- writereg_m  in  5  M-stage destination register.
- aluout_m  in  XLEN  M-stage ALU result.
- hold_e  in  1  EX busy (multicycle op); freeze everything.
- flush_e  in  1  branch redirect; kill the instruction entering E.
- stall_d  out  1  hold PC and IF/ID.
- valid_e  out  1  E register holds a real instruction.
- ctrl_e  out  ctrl_t  E control bundle.
- srca_e  out  XLEN  E operand A.
- writedata_e  out  XLEN  E operand B (register).
- signimm_e  out  XLEN  E sign-extended immediate.
- rs_e  out  5  E rs field.
- rt_e  out  5  E rt field.
- writereg_e  out  5  E destination register: rd_e if ctrl_e.regdst, else rt_e.
- pcplus4_e  out  32  E PC+4.
- stall_cycles  out  STALL_CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset (asynchronous): all E outputs 0, valid_e=0, stall_cycles=0. stall_d is combinational and reads 0 while the E/M inputs are idle.
- Read addresses: ra1/ra2 are purely combinational from instr_d.
- Register file timing: the register file writes on the falling edge, so a W-stage result is visible on rd1/rd2 in the same cycle. No W forwarding is needed.
- Forwarding, srcA_d: aluout_m when regwrite_m & !memtoreg_m & writereg_m!=0 & writereg_m==rs_d; otherwise rd1. srcB_d is the same using rt_d/rd2.
- Register 0: never forwarded; it reads 0 via the register file.
- Load-use hazard lu_hit, asserted when either holds:
  - load in E: valid_e & ctrl_e.memtoreg & writereg_e!=0 & matches the sources;
  - load in M: regwrite_m & memtoreg_m & writereg_m!=0 & matches the sources.
  - "Matches the sources" = rs_d, or rt_d when uses_rt_d.
  - Only evaluated when valid_d.
- Load-use latency: a use immediately after a load stalls 2 cycles; a use 2 slots after a load stalls 1 cycle.
- stall_d = lu_hit | hold_e.
- E register update, priority highest first:
  1. reset → clear.
  2. hold_e → keep all E state.
  3. flush_e | lu_hit | !valid_d → bubble: valid_e=0, ctrl_e=0; other fields don't-care (drive 0).
  4. Otherwise load from decode: valid_e=1, ctrl_e=ctrl_d, srca_e=srcA_d, writedata_e=srcB_d, signimm_e=sign-extend instr_d[15:0], rs/rt/rd fields, pcplus4_e.
- Simultaneous hold_e & flush_e: hold wins; the team's hazard unit reasserts flush_e after hold drops.
- Stall counter: stall_cycles increments on each rising edge where lu_hit & !hold_e, and saturates at all-ones (no wrap).
- Reset mid-stall: the E register clears immediately, which removes the E-load hazard source. Any M-source hazard persists until the M inputs clear.

Decomposition:
- Package mips_pkg:
  - ctrl_t packed struct: regwrite, memtoreg, memwrite, alusrc, regdst, branch, alucontrol[2:0].
  - CTRL_NOP = '0.
  - Register field position constants.
- One sub-module, hazard_fwd: purely combinational forwarding selects plus lu_hit. The E register and counter stay in the top module.

Test Plan:
- Reset in mid-stream: assert reset → valid_e=0, ctrl_e=0, stall_cycles=0 asynchronously, before the next clock edge.
- Forwarding from M:
  - Stimulus: regwrite_m=1, memtoreg_m=0, writereg_m=8, aluout_m=0x1234, instr_d add $t1,$t0,$t2 (rs=8), rd1=0xDEAD.
  - Required: after the clock edge, srca_e=0x1234.
  - Repeat with writereg_m=0 → srca_e=rd1 value.
- Back-to-back load-use:
  - Stimulus: lw $8 enters E; next decode is add using $8.
  - Required: stall_d=1 for 2 cycles, 2 bubbles (valid_e=0) enter E, then the add issues with rd1 data. stall_cycles=2.
- Use with rt not read: same as back-to-back load-use, but $8 is only in the rt position with uses_rt_d=0 → no stall.
- hold_e during a load-use stall: hold_e=1 for 3 cycles → E state frozen, stall_d=1, stall_cycles unchanged. After release the stall resumes correctly.
- Flush and counter saturation:
  - flush_e with a valid decode → valid_e=0 next cycle, and stall_d is unaffected by the flush.
  - Force stall_cycles to all-ones → it stays at all-ones after a further stall.
